// File: rtl/wb_port_arbiter.sv
// Shares one register-file write port between the MEM/WB pipe and a FIFO of long-latency results.
// Optional starvation guard is enabled by defining WB_ARB_STARVE_GUARD_EN.
module wb_port_arbiter #(
  parameter int QDEPTH       = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pipe_RegWrite,
  input  logic [4:0]              pipe_rd,
  input  logic [63:0]             pipe_data,
  input  logic                    mdu_valid,
  input  logic [4:0]              mdu_rd,
  input  logic [63:0]             mdu_data,
  output logic                    mdu_ready,
  output logic                    pipe_stall,
  output logic                    rf_we,
  output logic [4:0]              rf_rd,
  output logic [63:0]             rf_wdata,
  output logic [$clog2(QDEPTH):0] q_count
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  localparam logic [1:0] GNT_IDLE  = 2'd0;
  localparam logic [1:0] GNT_PIPE  = 2'd1;
  localparam logic [1:0] GNT_QUEUE = 2'd2;

  logic [4:0]    q_rd   [QDEPTH];
  logic [63:0]   q_data [QDEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;

  logic       q_nonempty_s;
  logic       pipe_active_s;
  logic       forced_s;
  logic       push_s;
  logic       pop_s;
  logic [1:0] grant_s;
  logic [4:0] head_rd_s;

  assign q_nonempty_s  = (q_count != {CW{1'b0}});
  assign pipe_active_s = pipe_RegWrite && (pipe_rd != 5'd0);
  assign mdu_ready     = (q_count < DEPTH_C);
  assign push_s        = mdu_valid && mdu_ready;
  assign pop_s         = (grant_s == GNT_QUEUE);
  assign head_rd_s     = q_rd[rd_ptr_r];

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT) + 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);

  logic [SW-1:0] starve_cnt_r;

  // Starvation counter: cycles the queue waited without a pop; saturates where it forces a grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_r <= {SW{1'b0}};
    end else if (!q_nonempty_s || pop_s) begin
      starve_cnt_r <= {SW{1'b0}};
    end else if (starve_cnt_r != STARVE_MAX) begin
      starve_cnt_r <= starve_cnt_r + STARVE_ONE;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  assign forced_s   = q_nonempty_s && (starve_cnt_r == STARVE_MAX);
  assign pipe_stall = forced_s && pipe_active_s;
`else
  assign forced_s   = 1'b0;
  assign pipe_stall = 1'b0;
`endif

  // Grant selection: forced queue head, then pipe, then queue head; only registered queue state
  // is consulted, so a result pushed this cycle cannot be granted until the next one.
  always_comb begin
    grant_s = GNT_IDLE;
    if (forced_s) begin
      grant_s = GNT_QUEUE;
    end else if (pipe_active_s) begin
      grant_s = GNT_PIPE;
    end else if (q_nonempty_s) begin
      grant_s = GNT_QUEUE;
    end else begin
      grant_s = GNT_IDLE;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      q_count  <= {CW{1'b0}};
    end else begin
      wr_ptr_r <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r <= pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   q_count <= q_count + CNT_ONE;
        2'b01:   q_count <= q_count - CNT_ONE;
        default: q_count <= q_count;
      endcase
    end
  end

  // Queue storage; contents are meaningless while the pointers say empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_rd[wr_ptr_r]   <= mdu_rd;
      q_data[wr_ptr_r] <= mdu_data;
    end
  end

  // Registered write port; popping an x0 result consumes the slot without a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_rd    <= 5'd0;
      rf_wdata <= 64'd0;
    end else begin
      case (grant_s)
        GNT_PIPE: begin
          rf_we    <= 1'b1;
          rf_rd    <= pipe_rd;
          rf_wdata <= pipe_data;
        end
        GNT_QUEUE: begin
          if (head_rd_s != 5'd0) begin
            rf_we    <= 1'b1;
            rf_rd    <= head_rd_s;
            rf_wdata <= q_data[rd_ptr_r];
          end else begin
            rf_we    <= 1'b0;
            rf_rd    <= rf_rd;
            rf_wdata <= rf_wdata;
          end
        end
        default: begin
          rf_we    <= 1'b0;
          rf_rd    <= rf_rd;
          rf_wdata <= rf_wdata;
        end
      endcase
    end
  end

endmodule
